filter_line_feeder: RTL and testbench
=====================================

Name: filter_line_feeder

Overview:
- Upstream sequencer for the 720-px 3x3 line filter.
- Accepts an RGB565 pixel stream over a valid/ready handshake and drives the filter's `f_din`/`f_wren`/`f_cursor` write-then-read protocol, one pixel at a time.
- Waits for the filter's ready flag (`f_rdy`), captures the filter output and re-emits it as a valid/ready stream with line and column tags.
- Also tracks column and line position and flags line-length errors.

Parameters:
- BLOCK_LENGTH, 720, pixels per line; cursor runs 0..BLOCK_LENGTH-1.
- MIN_WAIT, 3, minimum read-phase cycles before `f_dout` may be captured (covers filter RAM latency).
- TIMEOUT, 15, read-phase cycle count at which output is captured even without `f_rdy`; must be > MIN_WAIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  feeder can accept a pixel.
- s_data  in  16  input RGB565 pixel.
- s_sof  in  1  start of frame, qualified with the pixel handshake.
- s_eol  in  1  end of line, qualified with the pixel handshake.
- f_din  out  16  pixel to filter.
- f_wren  out  1  filter write enable.
- f_cursor  out  10  filter column cursor.
- f_dout  in  16  filter output pixel.
- f_rdy  in  1  filter output ready.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts the output pixel.
- m_data  out  16  filtered pixel.
- m_last  out  1  output pixel is the last of its line.
- col  out  10  column of the pixel in flight.
- line_cnt  out  10  line index within the frame.
- err_eol  out  1  sticky line-length error.
- err_timeout  out  1  sticky filter timeout.

Behaviour:

Reset (async, active-high):
- State goes to IDLE.
- All outputs are 0 except `s_ready`, which is 1.
- `col`, `line_cnt` and the wait counter are 0; both error flags are cleared.
- Reset mid-operation abandons the in-flight pixel; no `m_valid` is produced for it.

State machine, one pixel in flight:

IDLE
- `s_ready` = 1.
- On `s_valid` & `s_ready`: register `s_data` into `f_din` and latch `s_eol`.
- If `s_sof` = 1, force `col` = 0 and `line_cnt` = 0 for this pixel.
- Go to WRITE.

WRITE (exactly 1 cycle)
- `f_wren` = 1, `f_cursor` = `col`, `s_ready` = 0.
- Go to WAIT; wait counter = 0.

WAIT
- `f_wren` = 0, `f_cursor` held at `col`; wait counter increments each cycle.
- If `f_rdy` = 1 and counter >= MIN_WAIT-1: capture `f_dout` into `m_data`, go to OUT.
- Else if counter == TIMEOUT-1: capture `f_dout` anyway, set `err_timeout`, go to OUT.
- `f_rdy` is ignored in the early cycles (counter < MIN_WAIT-1).

OUT
- `m_valid` = 1; `m_data` and `m_last` are stable until `m_ready` = 1.
- `m_last` = 1 iff the latched eol was set or `col` == BLOCK_LENGTH-1.
- On `m_ready`: if `m_last` = 1, `col` becomes 0 and `line_cnt` increments (10-bit wrap, 1023 -> 0); otherwise `col` increments. Go to IDLE.

Line-length checks:
- eol with `col` != BLOCK_LENGTH-1 sets `err_eol`; that line still ends there.
- `col` == BLOCK_LENGTH-1 without eol sets `err_eol`; `col` still wraps to 0.

Timing:
- `m_valid` is never combinationally dependent on `m_ready`.
- `s_ready` is registered, derived from state.
- With `f_rdy` tied 1, MIN_WAIT = 3, and a pixel accepted at cycle 0: WRITE in cycle 1, WAIT in cycles 2-4, `m_valid` from cycle 5.
- With `m_ready` = 1, throughput is 1 pixel per 6 cycles.

Sticky errors:
- `err_eol` and `err_timeout` clear only on reset.

Test Plan:
- Reset, `f_rdy` = 1, `m_ready` = 1, one pixel 16'hF800 -> `f_wren` high exactly in cycle 1 with `f_cursor` = 0 and `f_din` = F800; `m_valid` in cycle 5 with `m_data` = `f_dout`; `col` = 1 afterwards.
- Stream 720 pixels with eol on the last -> cursors 0..719 in order; `m_last` only on pixel 719; then `col` = 0, `line_cnt` = 1, `err_eol` = 0.
- eol on pixel 100 -> `err_eol` = 1, `m_last` on that pixel, next `f_cursor` = 0, `line_cnt` incremented.
- `f_rdy` held 0 -> capture after exactly TIMEOUT (15) WAIT cycles, `err_timeout` = 1; `f_rdy` pulsed at counter 0 only -> not captured early.
- `m_ready` held 0 for 10 cycles in OUT -> `m_valid` and `m_data` stable, `s_ready` = 0, `f_wren` stays 0.
- `s_sof` at `col` = 300 -> that pixel is written with `f_cursor` = 0 and `line_cnt` = 0; assert reset during WAIT -> `m_valid` never rises, all outputs at reset values, `s_ready` = 1.

Source files
------------

// File: rtl/filter_line_feeder.sv
// ---------------------------------------------------------------------------
// filter_line_feeder
//
// Upstream sequencer for the 720-px 3x3 line filter. Takes one RGB565 pixel
// at a time from a valid/ready stream, writes it into the filter at the
// current column cursor, waits for the filter to produce its result, and
// re-emits that result as a valid/ready stream tagged with column, line and
// end-of-line information. Line-length violations and filter timeouts are
// reported through sticky error flags.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   s_valid/s_ready       input pixel handshake
//   s_data                input RGB565 pixel
//   s_sof, s_eol          start-of-frame / end-of-line, qualified by handshake
//   f_din, f_wren         pixel and write strobe towards the filter
//   f_cursor              filter column cursor (held for write and read)
//   f_dout, f_rdy         filter result and its ready flag
//   m_valid/m_ready       output pixel handshake
//   m_data, m_last        filtered pixel, last-of-line marker
//   col, line_cnt         position of the pixel in flight
//   err_eol, err_timeout  sticky line-length and filter-timeout errors
// ---------------------------------------------------------------------------
module filter_line_feeder #(
    parameter int BLOCK_LENGTH = 720,
    parameter int MIN_WAIT     = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic [15:0] f_din,
    output logic        f_wren,
    output logic [9:0]  f_cursor,
    input  logic [15:0] f_dout,
    input  logic        f_rdy,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last,
    output logic [9:0]  col,
    output logic [9:0]  line_cnt,
    output logic        err_eol,
    output logic        err_timeout
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] RDY_MIN  = WAIT_W'(MIN_WAIT - 1);
    localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [9:0]        COL_LAST = 10'(BLOCK_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t              state_q;
    logic                s_ready_q;
    logic [15:0]         f_din_q;
    logic                f_wren_q;
    logic [9:0]          col_q;
    logic [9:0]          line_q;
    logic                eol_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                m_valid_q;
    logic [15:0]         m_data_q;
    logic                m_last_q;
    logic                err_eol_q;
    logic                err_to_q;

    // Pixel sits at the final column of a nominal line.
    logic col_end_d;
    assign col_end_d = (col_q == COL_LAST);

    // Filter may be read once the RAM latency window has passed and it
    // reports ready; otherwise the timeout forces a capture.
    logic rdy_ok_d;
    logic timeout_d;
    assign rdy_ok_d  = f_rdy && (wait_q >= RDY_MIN);
    assign timeout_d = (wait_q == TO_LAST);

    // Single sequencer: one pixel in flight, every output registered.
    // The cursor is simply the column register, so it stays put from the
    // write cycle through the whole read phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
            f_din_q   <= '0;
            f_wren_q  <= 1'b0;
            col_q     <= '0;
            line_q    <= '0;
            eol_q     <= 1'b0;
            wait_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            err_eol_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid && s_ready_q) begin
                        f_din_q   <= s_data;
                        eol_q     <= s_eol;
                        f_wren_q  <= 1'b1;
                        s_ready_q <= 1'b0;
                        // Start of frame re-anchors the position for this pixel.
                        if (s_sof) begin
                            col_q  <= '0;
                            line_q <= '0;
                        end
                        state_q <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    f_wren_q <= 1'b0;
                    wait_q   <= '0;
                    state_q  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (rdy_ok_d || timeout_d) begin
                        m_data_q  <= f_dout;
                        m_valid_q <= 1'b1;
                        // Line ends on either marker; disagreement between the
                        // eol flag and the column count is a length error.
                        m_last_q  <= eol_q | col_end_d;
                        if (eol_q != col_end_d) begin
                            err_eol_q <= 1'b1;
                        end
                        if (!rdy_ok_d) begin
                            err_to_q <= 1'b1;
                        end
                        state_q <= ST_OUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        s_ready_q <= 1'b1;
                        if (m_last_q) begin
                            col_q  <= '0;
                            line_q <= line_q + 10'd1;
                        end else begin
                            col_q  <= col_q + 10'd1;
                        end
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign f_din       = f_din_q;
    assign f_wren      = f_wren_q;
    assign f_cursor    = col_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign col         = col_q;
    assign line_cnt    = line_q;
    assign err_eol     = err_eol_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_filter_line_feeder.sv
// ---------------------------------------------------------------------------
// tb_filter_line_feeder
//
// Directed bench for filter_line_feeder. A table of single-pixel records
// covers the handshake timing, the filter ready/timeout rules and the sof
// handling; hand-written sequences cover full lines, short lines, long
// lines, output back-pressure and reset in the middle of a read phase.
// ---------------------------------------------------------------------------
module tb_filter_line_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_eol;
    logic [15:0] f_din;
    logic        f_wren;
    logic [9:0]  f_cursor;
    logic [15:0] f_dout;
    logic        f_rdy;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [9:0]  col;
    logic [9:0]  line_cnt;
    logic        err_eol;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    // Observations captured by applyStimulus for one pixel transaction.
    logic        obsSreadyStart;
    logic        obsWrenAtWrite;
    int          obsWrenCount;
    logic [9:0]  obsCursor;
    logic [15:0] obsDin;
    logic [9:0]  obsLineWrite;
    int          obsWaits;
    logic [15:0] obsData;
    logic        obsLast;
    int          obsHoldErrors;
    logic        obsTimedOut;
    logic        obsValidAfter;
    logic        obsSreadyAfter;
    int          obsCycles;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        int          frdyMode;
        logic [15:0] fdout;
        logic [9:0]  expCursor;
        logic [9:0]  expLineWrite;
        int          expWaits;
        logic        expLast;
        logic [9:0]  expColAfter;
        logic [9:0]  expLineAfter;
        logic        expErrEol;
        logic        expErrTo;
    } VecRecord;

    VecRecord vectors[7];

    filter_line_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .s_eol       (s_eol),
        .f_din       (f_din),
        .f_wren      (f_wren),
        .f_cursor    (f_cursor),
        .f_dout      (f_dout),
        .f_rdy       (f_rdy),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .col         (col),
        .line_cnt    (line_cnt),
        .err_eol     (err_eol),
        .err_timeout (err_timeout)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    // Hard stop in case the design wedges somewhere unexpected.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=stuck required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " s_ready"},     32'(s_ready),     32'd1);
        checkOutput({tag, " m_valid"},     32'(m_valid),     32'd0);
        checkOutput({tag, " f_wren"},      32'(f_wren),      32'd0);
        checkOutput({tag, " f_cursor"},    32'(f_cursor),    32'd0);
        checkOutput({tag, " f_din"},       32'(f_din),       32'd0);
        checkOutput({tag, " m_data"},      32'(m_data),      32'd0);
        checkOutput({tag, " m_last"},      32'(m_last),      32'd0);
        checkOutput({tag, " col"},         32'(col),         32'd0);
        checkOutput({tag, " line_cnt"},    32'(line_cnt),    32'd0);
        checkOutput({tag, " err_eol"},     32'(err_eol),     32'd0);
        checkOutput({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    // Runs one complete pixel transaction starting and ending on a falling
    // edge with the feeder idle. frdyMode: 0 = f_rdy tied high, 1 = held low,
    // 2 = high only in the first read cycle, 3 = high only in the fourth.
    // stall = number of cycles m_ready is held low once m_valid is seen.
    task automatic applyStimulus(input logic [15:0] data, input logic sof, input logic eol,
                                 input int frdyMode, input int stall, input logic [15:0] fdoutVal);
        bit   done;
        longint tStart;
        obsWrenCount  = 0;
        obsHoldErrors = 0;
        obsTimedOut   = 1'b0;
        obsWaits      = 0;
        tStart        = $time;
        obsSreadyStart = s_ready;
        if (f_wren) obsWrenCount++;
        f_dout  = fdoutVal;
        f_rdy   = (frdyMode == 0);
        s_data  = data;
        s_sof   = sof;
        s_eol   = eol;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_data  = ~data;
        obsWrenAtWrite = f_wren;
        if (f_wren) obsWrenCount++;
        obsCursor    = f_cursor;
        obsDin       = f_din;
        obsLineWrite = line_cnt;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (m_valid) begin
                done = 1'b1;
            end else begin
                if (f_wren) obsWrenCount++;
                if (f_cursor !== obsCursor) obsHoldErrors++;
                case (frdyMode)
                    0:       f_rdy = 1'b1;
                    1:       f_rdy = 1'b0;
                    2:       f_rdy = (obsWaits == 0);
                    default: f_rdy = (obsWaits == 3);
                endcase
                obsWaits++;
                if (obsWaits > 40) begin
                    obsTimedOut = 1'b1;
                    done = 1'b1;
                end
            end
        end
        if (!obsTimedOut) begin
            m_ready = 1'b0;
            obsData = m_data;
            obsLast = m_last;
            if (f_wren) obsWrenCount++;
            f_dout = ~fdoutVal;
            f_rdy  = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!m_valid || m_data !== obsData || m_last !== obsLast || s_ready || f_wren)
                    obsHoldErrors++;
            end
            m_ready = 1'b1;
            @(negedge clk);
            obsValidAfter  = m_valid;
            obsSreadyAfter = s_ready;
        end
        m_ready   = 1'b1;
        f_rdy     = 1'b1;
        obsCycles = int'(($time - tStart) / 10);
    endtask

    // Full comparison of one table record against the last transaction.
    task automatic checkRecord(input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        checkOutput({t, " timeout"},      32'(obsTimedOut),    32'd0);
        checkOutput({t, " s_ready idle"}, 32'(obsSreadyStart), 32'd1);
        checkOutput({t, " wren@write"},   32'(obsWrenAtWrite), 32'd1);
        checkOutput({t, " wren count"},   32'(obsWrenCount),   32'd1);
        checkOutput({t, " cursor"},       32'(obsCursor),      32'(vectors[idx].expCursor));
        checkOutput({t, " f_din"},        32'(obsDin),         32'(vectors[idx].data));
        checkOutput({t, " line@write"},   32'(obsLineWrite),   32'(vectors[idx].expLineWrite));
        checkOutput({t, " wait cycles"},  32'(obsWaits),       32'(vectors[idx].expWaits));
        checkOutput({t, " m_data"},       32'(obsData),        32'(vectors[idx].fdout));
        checkOutput({t, " m_last"},       32'(obsLast),        32'(vectors[idx].expLast));
        checkOutput({t, " hold"},         32'(obsHoldErrors),  32'd0);
        checkOutput({t, " cycles"},       32'(obsCycles),      32'(vectors[idx].expWaits + 3));
        checkOutput({t, " m_valid drop"}, 32'(obsValidAfter),  32'd0);
        checkOutput({t, " s_ready back"}, 32'(obsSreadyAfter), 32'd1);
        checkOutput({t, " col after"},    32'(col),            32'(vectors[idx].expColAfter));
        checkOutput({t, " line after"},   32'(line_cnt),       32'(vectors[idx].expLineAfter));
        checkOutput({t, " err_eol"},      32'(err_eol),        32'(vectors[idx].expErrEol));
        checkOutput({t, " err_timeout"},  32'(err_timeout),    32'(vectors[idx].expErrTo));
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int validSeen;

        //           data      sof   eol   mode fdout     cur    lineW  wait last colA   lineA  eEol  eTo
        vectors[0] = '{16'hF800, 1'b1, 1'b0, 0, 16'h1111, 10'd0, 10'd0, 3,  1'b0, 10'd1, 10'd0, 1'b0, 1'b0};
        vectors[1] = '{16'h07E0, 1'b0, 1'b0, 0, 16'hA5A5, 10'd1, 10'd0, 3,  1'b0, 10'd2, 10'd0, 1'b0, 1'b0};
        vectors[2] = '{16'h001F, 1'b0, 1'b0, 3, 16'h5A5A, 10'd2, 10'd0, 4,  1'b0, 10'd3, 10'd0, 1'b0, 1'b0};
        vectors[3] = '{16'h0F0F, 1'b0, 1'b0, 2, 16'h0BAD, 10'd3, 10'd0, 15, 1'b0, 10'd4, 10'd0, 1'b0, 1'b1};
        vectors[4] = '{16'hFFFF, 1'b0, 1'b1, 1, 16'hC0DE, 10'd4, 10'd0, 15, 1'b1, 10'd0, 10'd1, 1'b1, 1'b1};
        vectors[5] = '{16'h1234, 1'b1, 1'b0, 0, 16'h4321, 10'd0, 10'd0, 3,  1'b0, 10'd1, 10'd0, 1'b1, 1'b1};
        vectors[6] = '{16'h2222, 1'b0, 1'b0, 0, 16'hBEEF, 10'd1, 10'd0, 3,  1'b0, 10'd2, 10'd0, 1'b1, 1'b1};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        f_dout  = '0;
        f_rdy   = 1'b1;
        m_ready = 1'b1;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single-pixel records: timing, ready window, timeout, sof.
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].data, vectors[i].sof, vectors[i].eol,
                          vectors[i].frdyMode, 0, vectors[i].fdout);
            checkRecord(i);
        end

        // A well-formed line of BLOCK_LENGTH pixels, then one with no eol.
        doReset();
        for (int i = 0; i < 720; i++) begin
            applyStimulus(16'(i), (i == 0), (i == 719), 0, 0, 16'(i * 3));
            checkOutput($sformatf("line0 cursor %0d", i), 32'(obsCursor), 32'(i));
            checkOutput($sformatf("line0 last %0d", i),   32'(obsLast),   32'(i == 719));
        end
        checkOutput("line0 col after",     32'(col),      32'd0);
        checkOutput("line0 line after",    32'(line_cnt), 32'd1);
        checkOutput("line0 err_eol",       32'(err_eol),  32'd0);
        for (int i = 0; i < 720; i++) begin
            applyStimulus(16'(i + 5), 1'b0, 1'b0, 0, 0, 16'(i + 7));
            checkOutput($sformatf("line1 cursor %0d", i), 32'(obsCursor), 32'(i));
            checkOutput($sformatf("line1 last %0d", i),   32'(obsLast),   32'(i == 719));
            if (i == 718) checkOutput("line1 err_eol early", 32'(err_eol), 32'd0);
        end
        checkOutput("line1 err_eol",       32'(err_eol),  32'd1);
        checkOutput("line1 col after",     32'(col),      32'd0);
        checkOutput("line1 line after",    32'(line_cnt), 32'd2);

        // Short line: eol on column 100.
        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(16'(i), (i == 0), 1'b0, 0, 0, 16'(i));
            if (i % 25 == 0) checkOutput($sformatf("short cursor %0d", i), 32'(obsCursor), 32'(i));
        end
        checkOutput("short err_eol before", 32'(err_eol), 32'd0);
        applyStimulus(16'h0100, 1'b0, 1'b1, 0, 0, 16'h7777);
        checkOutput("short eol cursor",  32'(obsCursor), 32'd100);
        checkOutput("short eol last",    32'(obsLast),   32'd1);
        checkOutput("short err_eol",     32'(err_eol),   32'd1);
        checkOutput("short line after",  32'(line_cnt),  32'd1);
        applyStimulus(16'h0200, 1'b0, 1'b0, 0, 0, 16'h8888);
        checkOutput("short next cursor", 32'(obsCursor),    32'd0);
        checkOutput("short next line",   32'(obsLineWrite), 32'd1);
        checkOutput("short next last",   32'(obsLast),      32'd0);

        // Advance to column 300, then sof mid-line with output back-pressure.
        for (int i = 1; i < 300; i++) begin
            applyStimulus(16'(i), 1'b0, 1'b0, 0, 0, 16'(i));
        end
        checkOutput("sof col before", 32'(col), 32'd300);
        applyStimulus(16'h3C3C, 1'b1, 1'b0, 0, 10, 16'hD00D);
        checkOutput("sof cursor",      32'(obsCursor),     32'd0);
        checkOutput("sof line@write",  32'(obsLineWrite),  32'd0);
        checkOutput("sof f_din",       32'(obsDin),        32'h3C3C);
        checkOutput("stall m_data",    32'(obsData),       32'hD00D);
        checkOutput("stall hold",      32'(obsHoldErrors), 32'd0);
        checkOutput("stall wren",      32'(obsWrenCount),  32'd1);
        checkOutput("stall cycles",    32'(obsCycles),     32'd16);
        checkOutput("sof col after",   32'(col),           32'd1);
        checkOutput("sof line after",  32'(line_cnt),      32'd0);

        // Reset asserted during the read phase abandons the pixel.
        f_rdy   = 1'b0;
        s_data  = 16'hABCD;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        checkOutput("abort wren@write", 32'(f_wren), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("midwait");
        @(negedge clk);
        reset = 1'b0;
        f_rdy = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) validSeen++;
        end
        checkOutput("abort m_valid",  32'(validSeen), 32'd0);
        checkOutput("abort s_ready",  32'(s_ready),   32'd1);
        checkOutput("abort f_wren",   32'(f_wren),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
